// File: rtl/cic_sample_fifo_pkg.sv
// Shared widths and saturation limits for the CIC sample FIFO slice.
package cic_pkg;
    localparam int              CIC_OUT_W  = 32;
    localparam int              SAMPLE_W   = 16;
    localparam logic [15:0]     SAT_MAX    = 16'h7FFF;
    localparam logic [15:0]     SAT_MIN    = 16'h8000;
    localparam int              FIFO_DEPTH = 16;
endpackage

// File: rtl/cic_sample_fifo_if.sv
// Streaming interface: CIC word in with strobe, sample out with valid/ready.
interface cic_sample_fifo_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
);
    logic [IN_W-1:0]  din;
    logic             din_rdy;
    logic [OUT_W-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;

    modport master (output din, output din_rdy, output dout_ready,
                    input  dout, input  dout_valid);
    modport slave  (input  din, input  din_rdy, input  dout_ready,
                    output dout, output dout_valid);
endinterface

// File: rtl/cic_sample_fifo_sat_shift.sv
// Arithmetic right shift of a CIC word followed by signed saturation.
module sat_shift
    import cic_pkg::*;
#(
    parameter int IN_W  = CIC_OUT_W,
    parameter int OUT_W = SAMPLE_W
) (
    input  logic [IN_W-1:0]  i_din,
    input  logic [4:0]       i_shift,
    output logic [OUT_W-1:0] o_sample,
    output logic             o_clipped
);
    logic signed [IN_W-1:0] w_s;
    logic signed [IN_W-1:0] w_hi;
    logic signed [IN_W-1:0] w_lo;

    assign w_s  = $signed(i_din) >>> i_shift;
    assign w_hi = $signed({{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    assign w_lo = $signed({{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});

    // Clamp to the signed output range, flagging any clamp.
    always_comb begin
        o_sample  = w_s[OUT_W-1:0];
        o_clipped = 1'b0;
        if (w_s > w_hi) begin
            o_sample  = SAT_MAX;
            o_clipped = 1'b1;
        end else if (w_s < w_lo) begin
            o_sample  = SAT_MIN;
            o_clipped = 1'b1;
        end else begin
            o_sample  = w_s[OUT_W-1:0];
            o_clipped = 1'b0;
        end
    end
endmodule

// File: rtl/cic_sample_fifo.sv
// Scales and saturates CIC output words, then buffers them in a FWFT FIFO
// with sticky overflow/clip flags.
module cic_sample_fifo
    import cic_pkg::*;
#(
    parameter int IN_W   = CIC_OUT_W,
    parameter int OUT_W  = SAMPLE_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        shift,
    input  logic              flag_clr,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              clip,
    cic_sample_fifo_if.slave  bus
);
    localparam logic [ADDR_W:0]   L_FULL  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   L_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] P_ONE   = ADDR_W'(1);

    logic [OUT_W-1:0]  w_sample;
    logic              w_clipped;
    logic              r_p_vld;
    logic [OUT_W-1:0]  r_p_data;
    logic [OUT_W-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_overflow;
    logic              r_clip;
    logic              w_full;
    logic              w_rd;
    logic              w_wr;
    logic              w_ovf_set;
    logic              w_clip_set;

    sat_shift #(.IN_W(IN_W), .OUT_W(OUT_W)) u_sat_shift (
        .i_din     (bus.din),
        .i_shift   (shift),
        .o_sample  (w_sample),
        .o_clipped (w_clipped)
    );

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_full     = (r_level == L_FULL);
    assign w_rd       = (r_level != '0) & bus.dout_ready;
    assign w_wr       = r_p_vld & (~w_full | w_rd);
    assign w_ovf_set  = r_p_vld & w_full & ~w_rd;
    assign w_clip_set = bus.din_rdy & w_clipped;

    // Stage-1 register: scaled sample and its valid strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p_vld  <= 1'b0;
            r_p_data <= '0;
        end else begin
            r_p_vld <= bus.din_rdy;
            if (bus.din_rdy) begin
                r_p_data <= w_sample;
            end
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_p_data;
        end
    end

    // Pointers, occupancy and sticky flags (a set beats a clear).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_clip     <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + P_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + P_ONE;
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + L_ONE;
                2'b01:   r_level <= r_level - L_ONE;
                default: r_level <= r_level;
            endcase
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (flag_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_clip_set) begin
                r_clip <= 1'b1;
            end else if (flag_clr) begin
                r_clip <= 1'b0;
            end
        end
    end

    assign level          = r_level;
    assign overflow       = r_overflow;
    assign clip           = r_clip;
    assign bus.dout_valid = (r_level != '0);
    assign bus.dout       = (r_level != '0) ? r_mem[r_rd_ptr] : '0;
endmodule

// File: tb/tb_cic_sample_fifo.sv
// Directed self-checking bench for cic_sample_fifo.
module tb_cic_sample_fifo;
    logic       clk;
    logic       rst;
    logic [4:0] shift;
    logic       flag_clr;
    logic [4:0] level;
    logic       overflow;
    logic       clip;
    int         n_cmp;
    int         n_err;

    cic_sample_fifo_if #(.IN_W(32), .OUT_W(16)) u_if ();

    cic_sample_fifo u_dut (
        .clk      (clk),
        .rst      (rst),
        .shift    (shift),
        .flag_clr (flag_clr),
        .level    (level),
        .overflow (overflow),
        .clip     (clip),
        .bus      (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [4:0] sh);
        u_if.din     = d;
        shift        = sh;
        u_if.din_rdy = 1'b1;
        tick();
        u_if.din_rdy = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        u_if.dout_ready = 1'b1;
        tick();
        u_if.dout_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        shift = 5'd0;
        flag_clr = 1'b0;
        u_if.din = 32'd0;
        u_if.din_rdy = 1'b0;
        u_if.dout_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst_valid", {31'd0, u_if.dout_valid}, 32'd0);
        chk("rst_level", {27'd0, level}, 32'd0);
        chk("rst_dout", {16'd0, u_if.dout}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_clip", {31'd0, clip}, 32'd0);

        // Basic scaling and two-cycle latency.
        push(32'h0000_1234, 5'd4);
        chk("t2_dout", {16'd0, u_if.dout}, 32'h0000_0123);
        chk("t2_valid", {31'd0, u_if.dout_valid}, 32'd1);
        chk("t2_level", {27'd0, level}, 32'd1);
        pop_one();
        chk("t2_level0", {27'd0, level}, 32'd0);
        chk("t2_valid0", {31'd0, u_if.dout_valid}, 32'd0);

        // Saturation and sign handling.
        push(32'h0010_0000, 5'd0);
        chk("t3_posmax", {16'd0, u_if.dout}, 32'h0000_7FFF);
        chk("t3_clip1", {31'd0, clip}, 32'd1);
        pop_one();
        push(32'hFFF0_0000, 5'd0);
        chk("t3_negmin", {16'd0, u_if.dout}, 32'h0000_8000);
        pop_one();
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        chk("t3_clr", {31'd0, clip}, 32'd0);
        push(32'hFFFF_FFF0, 5'd4);
        chk("t3_neg1", {16'd0, u_if.dout}, 32'h0000_FFFF);
        chk("t3_noclip", {31'd0, clip}, 32'd0);
        pop_one();

        // Overflow: 17 writes into a 16-deep FIFO.
        shift = 5'd0;
        for (int i = 1; i <= 17; i++) begin
            u_if.din = i;
            u_if.din_rdy = 1'b1;
            tick();
        end
        u_if.din_rdy = 1'b0;
        tick();
        chk("t4_level", {27'd0, level}, 32'd16);
        chk("t4_ovf", {31'd0, overflow}, 32'd1);
        u_if.dout_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("t4_drain", {16'd0, u_if.dout}, i);
            tick();
        end
        u_if.dout_ready = 1'b0;
        chk("t4_empty", {27'd0, level}, 32'd0);
        chk("t4_novalid", {31'd0, u_if.dout_valid}, 32'd0);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        chk("t4_ovfclr", {31'd0, overflow}, 32'd0);

        // Write into a full FIFO in the same cycle as a read.
        for (int i = 0; i < 16; i++) begin
            u_if.din = 32'd100 + i;
            u_if.din_rdy = 1'b1;
            tick();
        end
        u_if.din_rdy = 1'b0;
        tick();
        chk("t5_full", {27'd0, level}, 32'd16);
        u_if.din = 32'd200;
        u_if.din_rdy = 1'b1;
        tick();
        u_if.din_rdy = 1'b0;
        u_if.dout_ready = 1'b1;
        tick();
        u_if.dout_ready = 1'b0;
        chk("t5_level", {27'd0, level}, 32'd16);
        chk("t5_ovf", {31'd0, overflow}, 32'd0);
        u_if.dout_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk("t5_drain", {16'd0, u_if.dout}, 32'd100 + i);
            tick();
        end
        chk("t5_last", {16'd0, u_if.dout}, 32'd200);
        tick();
        u_if.dout_ready = 1'b0;
        chk("t5_empty", {27'd0, level}, 32'd0);

        // Full throughput streaming.
        u_if.dout_ready = 1'b1;
        shift = 5'd0;
        for (int k = 0; k < 8; k++) begin
            u_if.din = k;
            u_if.din_rdy = 1'b1;
            tick();
            if (k >= 1) begin
                chk("t6_dout", {16'd0, u_if.dout}, k - 1);
                chk("t6_valid", {31'd0, u_if.dout_valid}, 32'd1);
                chk("t6_level", {31'd0, (level > 5'd1)}, 32'd0);
            end
        end
        u_if.din_rdy = 1'b0;
        tick();
        chk("t6_dout7", {16'd0, u_if.dout}, 32'd7);
        chk("t6_level1", {27'd0, level}, 32'd1);
        tick();
        chk("t6_done", {31'd0, u_if.dout_valid}, 32'd0);
        u_if.dout_ready = 1'b0;

        // Asynchronous reset with entries queued and clip set.
        u_if.din = 32'h0010_0000;
        u_if.din_rdy = 1'b1;
        tick();
        for (int i = 1; i < 5; i++) begin
            u_if.din = i;
            tick();
        end
        u_if.din_rdy = 1'b0;
        tick();
        chk("t1_pre_level", {27'd0, level}, 32'd5);
        chk("t1_pre_clip", {31'd0, clip}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t1_valid", {31'd0, u_if.dout_valid}, 32'd0);
        chk("t1_level", {27'd0, level}, 32'd0);
        chk("t1_dout", {16'd0, u_if.dout}, 32'd0);
        chk("t1_ovf", {31'd0, overflow}, 32'd0);
        chk("t1_clip", {31'd0, clip}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("t1_stay", {27'd0, level}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cic_sample_fifo.md
Name: cic_sample_fifo

Overview:
- Downstream stage of the CIC decimator. Consumes the 32-bit decimated word `out` and its one-cycle `out_rdy` strobe.
- Scales each word by a programmable arithmetic right shift and saturates it to a signed 16-bit sample.
- Buffers samples in a first-word-fall-through FIFO with a valid/ready read port, used by the downstream correlator/host interface.
- Flags overflow and clipping with sticky bits.

Parameters:
- IN_W, 32: input word width; matches the CIC output.
- OUT_W, 16: output sample width, signed.
- DEPTH, 16: FIFO depth in entries; must be a power of 2.
- ADDR_W, 4: log2(DEPTH).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset. One clock; reset is asynchronous and active-low.
- din, input, IN_W: CIC output word, two's complement.
- din_rdy, input, 1: one-cycle strobe; din is valid when high.
- shift, input, 5: right-shift amount, 0..31.
- dout, output, OUT_W: FIFO head sample.
- dout_valid, output, 1: FIFO not empty.
- dout_ready, input, 1: consumer accepts dout this cycle.
- level, output, ADDR_W+1: current occupancy, 0..DEPTH.
- overflow, output, 1: sticky; a sample was dropped because the FIFO was full.
- clip, output, 1: sticky; a sample saturated.
- flag_clr, input, 1: clears overflow and clip.

Behaviour:
- Reset (rst=0, asynchronous): pointers=0, level=0, dout_valid=0, dout=0, overflow=0, clip=0, stage-1 valid=0. Takes effect immediately; any in-flight sample is discarded.
- Stage 1, registered on a din_rdy cycle:
  - shift is sampled in that same cycle; a shift change affects only later samples.
  - s = din >>> shift, arithmetic shift, truncation toward minus infinity, no rounding.
  - If s > 2^(OUT_W-1)-1, the result is 0x7FFF. If s < -2^(OUT_W-1), the result is 0x8000. In both cases clip is set.
  - Otherwise the result is s[OUT_W-1:0].
  - p_vld follows din_rdy with one cycle of delay.
- Stage 2, FIFO write:
  - When p_vld=1 and the FIFO is not full, write p_data at wr_ptr and increment wr_ptr.
  - When the FIFO is full and no read occurs in the same cycle, drop the sample and set overflow.
  - When the FIFO is full and a read occurs in the same cycle (dout_valid & dout_ready), accept the write. level stays at DEPTH and overflow is not set.
- Read:
  - A transfer occurs when dout_valid & dout_ready; rd_ptr increments.
  - dout always reflects mem[rd_ptr] while dout_valid=1. dout_valid = (level != 0).
  - dout_ready while empty has no effect.
- Latency: din_rdy at cycle N gives a write at edge N+2; dout_valid=1 and dout holds the sample from cycle N+2 when the FIFO was empty.
- Pointers: ADDR_W bits, wrap modulo DEPTH. level update rules:
  - +1 on a write alone.
  - -1 on a read alone.
  - Unchanged when a write and a read occur in the same cycle.
  - Never exceeds DEPTH and never underflows.
- Sticky flags: flag_clr clears overflow and clip. If a new overflow or clip event occurs in the same cycle as flag_clr, the set wins.
- Back-to-back din_rdy on consecutive cycles must be accepted; full throughput is one sample per clock.

Decomposition:
- Package cic_pkg holds:
  - CIC_OUT_W=32 and SAMPLE_W=16;
  - the signed saturation limits SAT_MAX=16'h7FFF and SAT_MIN=16'h8000;
  - the default FIFO_DEPTH=16.
- One sub-module: sat_shift, a combinational arithmetic shift plus saturation producing {sample, clipped}. It is instantiated ahead of the stage-1 register.
- FIFO storage and pointer logic stay in the top module.

Test Plan:
1. Hold rst=0 mid-stream with 5 entries queued → dout_valid=0, level=0, dout=0, overflow=0, clip=0 immediately, without waiting for a clock edge.
2. din=32'h00001234, shift=4, din_rdy pulse at cycle N → dout=16'h0123, dout_valid=1 and level=1 at N+2. With dout_ready=1 → level=0 next cycle.
3. Saturation and sign handling:
   - din=32'h00100000, shift=0 → dout=16'h7FFF, clip=1.
   - din=32'hFFF00000, shift=0 → dout=16'h8000.
   - din=32'hFFFFFFF0, shift=4 → dout=16'hFFFF, clip unchanged.
   - Pulse flag_clr → clip=0.
4. dout_ready=0; write 17 samples with values 1..17 → level=16, overflow=1. Then draining with dout_ready=1 yields 1..16 in order; 17 never appears and level returns to 0.
5. FIFO full; din_rdy pulse arriving at stage 2 in the same cycle as dout_ready=1 → level stays 16, overflow stays 0, and the new sample appears as the last entry.
6. din_rdy held high 8 consecutive cycles with din=0..7, shift=0, dout_ready=1 → 8 outputs 0..7 on consecutive cycles starting at N+2, and level never exceeds 1.
